// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between the UART receiver's user strobe and a valid/ready consumer.
// Bytes arriving while full are dropped and recorded in a sticky flag and a saturating counter.
module uart_rx_fifo #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_DEPTH      = 16,
    parameter int P_ADDR_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_DATA_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    output logic [P_DATA_WIDTH-1:0] o_user_data,
    output logic                    o_user_valid,
    input  logic                    i_user_ready,
    output logic [P_ADDR_WIDTH:0]   o_count,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_overflow,
    output logic [7:0]              o_drop_count,
    input  logic                    i_clr_overflow
);

    localparam logic [P_ADDR_WIDTH:0]   LP_FULL_CNT = (P_ADDR_WIDTH+1)'(P_DEPTH);
    localparam logic [P_ADDR_WIDTH:0]   LP_CNT_ONE  = (P_ADDR_WIDTH+1)'(1);
    localparam logic [P_ADDR_WIDTH-1:0] LP_PTR_ONE  = P_ADDR_WIDTH'(1);

    logic [P_DATA_WIDTH-1:0] mem_r [P_DEPTH];
    logic [P_ADDR_WIDTH-1:0] wr_ptr_r;
    logic [P_ADDR_WIDTH-1:0] rd_ptr_r;
    logic [P_ADDR_WIDTH:0]   count_r;
    logic                    full_r;
    logic                    empty_r;
    logic                    overflow_r;
    logic [7:0]              drop_count_r;

    logic                    push_s;
    logic                    pop_s;
    logic                    drop_s;
    logic [P_ADDR_WIDTH:0]   count_next_s;

    // Transfer qualification and next occupancy.
    always_comb begin
        pop_s        = 1'b0;
        push_s       = 1'b0;
        drop_s       = 1'b0;
        count_next_s = count_r;
        pop_s  = !empty_r && i_user_ready;
        // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
        push_s = i_rx_valid && (!full_r || pop_s);
        drop_s = i_rx_valid && full_r && !pop_s;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + LP_CNT_ONE;
            2'b01:   count_next_s = count_r - LP_CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage write; the array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (push_s && !i_rst) begin
            mem_r[wr_ptr_r] <= i_rx_data;
        end
    end

    // Pointers, occupancy and full/empty status.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + LP_PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + LP_PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == LP_FULL_CNT);
            empty_r <= (count_next_s == '0);
        end
    end

    // Overflow bookkeeping; a drop in the same cycle as a clear takes precedence.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (i_clr_overflow) begin
                drop_count_r <= 8'd1;
            end else if (drop_count_r != 8'hFF) begin
                drop_count_r <= drop_count_r + 8'd1;
            end else begin
                drop_count_r <= drop_count_r;
            end
        end else if (i_clr_overflow) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else begin
            overflow_r   <= overflow_r;
            drop_count_r <= drop_count_r;
        end
    end

    assign o_user_data  = mem_r[rd_ptr_r];
    assign o_user_valid = !empty_r;
    assign o_count      = count_r;
    assign o_full       = full_r;
    assign o_empty      = empty_r;
    assign o_overflow   = overflow_r;
    assign o_drop_count = drop_count_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] user_data;
    logic       user_valid;
    logic       user_ready = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clr_overflow = 1'b0;

    logic [7:0] mdl_q [$];
    logic       mdl_ovf = 1'b0;
    int         mdl_drops = 0;
    logic [7:0] last_pop = 8'h00;
    logic       popped_aa = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_fifo #(.P_DATA_WIDTH(8), .P_DEPTH(DEPTH), .P_ADDR_WIDTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_user_data(user_data), .o_user_valid(user_valid), .i_user_ready(user_ready),
        .o_count(count), .o_full(full), .o_empty(empty), .o_overflow(overflow),
        .o_drop_count(drop_count), .i_clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model over the edge, compare outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic rdy,
                        input logic clr, input logic r);
        logic m_full, m_pop, m_push, m_drop;
        rx_valid = v; rx_data = d; user_ready = rdy; clr_overflow = clr; rst = r;
        m_full = (mdl_q.size() == DEPTH);
        m_pop  = (mdl_q.size() > 0) && rdy;
        m_push = v && (!m_full || m_pop);
        m_drop = v && m_full && !m_pop;
        @(posedge clk);
        #1;
        if (r) begin
            mdl_q.delete();
            mdl_ovf = 1'b0;
            mdl_drops = 0;
        end else begin
            if (m_pop) begin
                last_pop = mdl_q.pop_front();
                if (last_pop == 8'hAA) popped_aa = 1'b1;
            end
            if (m_push) mdl_q.push_back(d);
            if (clr) begin
                mdl_ovf = 1'b0;
                mdl_drops = 0;
            end
            if (m_drop) begin
                mdl_ovf = 1'b1;
                if (mdl_drops < 255) mdl_drops++;
            end
        end
        check_eq("count", 32'(count), 32'(mdl_q.size()));
        check_eq("valid", 32'(user_valid), 32'(mdl_q.size() != 0));
        check_eq("empty", 32'(empty), 32'(mdl_q.size() == 0));
        check_eq("full", 32'(full), 32'(mdl_q.size() == DEPTH));
        check_eq("overflow", 32'(overflow), 32'(mdl_ovf));
        check_eq("drop_count", 32'(drop_count), 32'(mdl_drops));
        if (mdl_q.size() != 0) check_eq("data", 32'(user_data), 32'(mdl_q[0]));
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        int p_valid, p_ready;
        // 1: reset held with incoming strobes
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        check_eq("rst_count", 32'(count), 32'd0);
        idle(1, 1'b0);

        // 2: single byte, then pop
        step(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
        check_eq("t2_data", 32'(user_data), 32'h0A);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_eq("t2_pop", 32'(last_pop), 32'h0A);

        // 3: fill, drop 0xAA, drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check_eq("t3_full", 32'(full), 32'd1);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        check_eq("t3_drops", 32'(drop_count), 32'd1);
        idle(DEPTH, 1'b1);
        check_eq("t3_last", 32'(last_pop), 32'h0F);
        check_eq("t3_no_aa", 32'(popped_aa), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // 4: push and pop while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check_eq("t4_pop", 32'(last_pop), 32'h00);
        check_eq("t4_count", 32'(count), 32'd16);
        check_eq("t4_ovf", 32'(overflow), 32'd0);
        idle(DEPTH, 1'b1);
        check_eq("t4_last", 32'(last_pop), 32'h55);

        // 5: sparse stream with ready held high
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
            idle(2, 1'b1);
        end

        // 6a: reset with stored data
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        // 6b: saturation
        for (int i = 0; i < DEPTH + 300; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        check_eq("t6_sat", 32'(drop_count), 32'd255);
        // 6c: drop and clear together
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        check_eq("t6_clr_drop", 32'(drop_count), 32'd1);

        // Randomized traffic with varying fill pressure
        for (int blk = 0; blk < 20; blk++) begin
            p_valid = $urandom_range(20, 90);
            p_ready = $urandom_range(10, 90);
            for (int i = 0; i < 150; i++) begin
                step(1'($urandom_range(0, 99) < p_valid), 8'($urandom),
                     1'($urandom_range(0, 99) < p_ready),
                     1'($urandom_range(0, 99) < 3),
                     1'($urandom_range(0, 999) < 4));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the UART receiver's user output and the user logic.
- The receiver presents one byte per frame as a single-cycle valid strobe and cannot be stalled.
- This block stores bytes in a circular FIFO and re-presents them on a valid/ready stream, so the consumer may apply backpressure.
- Bytes that arrive while the FIFO is full are dropped. Each drop sets a sticky overflow flag and increments a saturating drop counter.

Parameters:
P_DATA_WIDTH, 8, byte width; matches the receiver's data width.
P_DEPTH, 16, number of FIFO entries; must be a power of 2, minimum 2.
P_ADDR_WIDTH, 4, log2(P_DEPTH); pointer width.

Ports:
i_clk  input  1  system clock; single clock domain.
i_rst  input  1  reset; synchronous, active-high.
i_rx_data  input  P_DATA_WIDTH  byte from the UART receiver.
i_rx_valid  input  1  single-cycle strobe; i_rx_data is valid in this cycle.
o_user_data  output  P_DATA_WIDTH  head-of-FIFO byte; meaningful only while o_user_valid=1.
o_user_valid  output  1  FIFO non-empty.
i_user_ready  input  1  consumer accepts the byte; a transfer (pop) occurs when valid&&ready.
o_count  output  P_ADDR_WIDTH+1  number of stored entries, 0..P_DEPTH.
o_full  output  1  o_count==P_DEPTH.
o_empty  output  1  o_count==0.
o_overflow  output  1  sticky; set when a byte is dropped.
o_drop_count  output  8  dropped-byte counter; saturates at 255.
i_clr_overflow  input  1  clears o_overflow and o_drop_count.

Behaviour:
- Reset: every output takes its reset value at the first i_clk edge with i_rst=1.
  - Reset values: o_user_valid=0, o_empty=1, o_full=0, o_count=0, o_overflow=0, o_drop_count=0.
  - Write and read pointers are cleared to 0.
  - Storage array contents are not reset.
  - Reset mid-operation discards all stored entries and any push/pop in that cycle.
- Storage is a register array of P_DEPTH entries.
  - o_user_data = mem[rd_ptr], combinational read.
  - o_user_valid = !o_empty.
- Push = i_rx_valid && (!o_full || pop).
  - On push, mem[wr_ptr] <= i_rx_data and wr_ptr increments.
- Pop = o_user_valid && i_user_ready; rd_ptr increments.
  - i_user_ready while empty has no effect.
- Pointers wrap from P_DEPTH-1 to 0 (natural P_ADDR_WIDTH-bit rollover).
- o_count update: +1 on push only, -1 on pop only, unchanged on both or neither.
  - o_full and o_empty are derived from the registered count.
- Latency: a byte pushed at edge N is visible on o_user_data/o_user_valid after edge N. There is no same-cycle bypass when empty.
- Full, with push and pop in the same cycle: the pop frees a slot, so the byte is accepted. o_count stays P_DEPTH and no overflow is recorded.
- Drop = i_rx_valid && o_full && !pop.
  - The byte is discarded and the FIFO contents are untouched.
  - o_overflow <= 1.
  - o_drop_count increments unless it is already 255.
- i_clr_overflow: o_overflow <= 0 and o_drop_count <= 0.
  - If a drop occurs in the same cycle, the drop wins: o_overflow=1 and o_drop_count=1.
- Ordering is strict FIFO. No data is reordered or duplicated.

Test Plan:
1. Hold i_rst=1 for 2 cycles with i_rx_valid=1 -> o_user_valid=0, o_empty=1, o_count=0, o_overflow=0, o_drop_count=0; nothing stored.
2. Push 0x0A with i_user_ready=0 -> next cycle o_user_valid=1, o_user_data=0x0A, o_count=1. Raise ready for 1 cycle -> o_count=0, o_user_valid=0.
3. Push 0x00..0x0F with ready=0 -> o_full=1, o_count=16. Then push 0xAA -> dropped, o_overflow=1, o_drop_count=1. Drain -> reads 0x00..0x0F in order, 0xAA never appears.
4. With the FIFO full, push 0x55 and pop in the same cycle -> 0x00 popped, 0x55 accepted, o_count stays 16, o_overflow stays 0. 0x55 is the last byte out.
5. Stream 40 bytes, 1 per 3 cycles, with ready=1 throughout -> each byte appears 1 cycle after its push, in order. o_count never exceeds 1; pointers wrap twice.
6. Cases:
   - Load 5 bytes, then pulse i_rst -> o_count=0, o_user_valid=0.
   - Overfill by 300 bytes -> o_drop_count=255 (saturated).
   - Drop and i_clr_overflow in the same cycle -> o_overflow=1, o_drop_count=1.
